// File: rtl/mfm_writer.sv
// mfm_writer: streams bytes from an upstream FIFO to a floppy write head as MFM
// bit cells. Each byte is sent MSB first as 16 cells (clock cell, data cell).
// A cell of value 1 produces a write pulse for the first PULSE_CLKS clocks of
// the cell. One prefetch register (NEXT) allows byte-to-byte streaming with no
// gap cycles.
//
// Optional build macro: MFM_WRITER_UNDERRUN_FILL_EN
//   defined   - on FIFO starvation keep the gate high and send 0x4E gap bytes
//               until FIFO data is available again
//   undefined - on FIFO starvation drop the gate and return to IDLE
//
// state  | meaning
// IDLE   | no session; waiting for enable with FIFO data
// FETCH  | first FIFO read issued, waiting for its data
// SHIFT  | gate high, cells being sent from the shifter
module mfm_writer #(
    parameter int CLKS_PER_CELL = 16,
    parameter int PULSE_CLKS    = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Enable,
    input  logic       i_Fifo_Empty,
    output logic       o_Fifo_Rd_En,
    input  logic       i_Fifo_Rd_DV,
    input  logic [7:0] i_Fifo_Rd_Data,
    output logic       o_Write_Gate,
    output logic       o_Write_Pulse,
    output logic       o_Busy,
    output logic       o_Underrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam logic [7:0] CELL_LAST = 8'(CLKS_PER_CELL - 1);
    localparam logic [7:0] PULSE_LEN = 8'(PULSE_CLKS);
    localparam logic [7:0] GAP_BYTE  = 8'h4E;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] cell_q, cell_d;
    logic [7:0] clk_cnt_q, clk_cnt_d;
    logic       prev_q, prev_d;
    logic [7:0] next_q, next_d;
    logic       next_vld_q, next_vld_d;
    logic       rd_out_q, rd_out_d;
    logic       underrun_q, underrun_d;

    logic       rd_en;
    logic       dv_acc;
    logic       cell_end;
    logic       byte_end;
    logic       data_bit;
    logic       cell_val;

    // Cell decode: even cells are clock cells, odd cells carry the data bit.
    always_comb begin
        dv_acc   = i_Fifo_Rd_DV & rd_out_q;
        cell_end = (clk_cnt_q == CELL_LAST);
        byte_end = cell_end && (cell_q == 4'd15);
        data_bit = shift_q[3'd7 - cell_q[3:1]];
        cell_val = cell_q[0] ? data_bit : (~prev_q & ~data_bit);
    end

    // Next-state, counters, prefetch and FIFO read strobe.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cell_d     = cell_q;
        clk_cnt_d  = clk_cnt_q;
        prev_d     = prev_q;
        next_d     = next_q;
        next_vld_d = next_vld_q;
        underrun_d = underrun_q;
        rd_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                prev_d     = 1'b0;
                next_vld_d = 1'b0;
                if (i_Enable && !i_Fifo_Empty && !rd_out_q) begin
                    rd_en      = 1'b1;
                    underrun_d = 1'b0;
                    state_d    = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (dv_acc) begin
                    shift_d   = i_Fifo_Rd_Data;
                    cell_d    = 4'd0;
                    clk_cnt_d = 8'd0;
                    prev_d    = 1'b0;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (!next_vld_q && !rd_out_q && !i_Fifo_Empty && i_Enable) begin
                    rd_en = 1'b1;
                end
                if (dv_acc) begin
                    next_d     = i_Fifo_Rd_Data;
                    next_vld_d = 1'b1;
                end

                if (cell_end) begin
                    clk_cnt_d = 8'd0;
                    cell_d    = cell_q + 4'd1;
                    if (cell_q[0]) begin
                        prev_d = data_bit;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end

                // Byte boundary: a read landing on this very cycle counts as NEXT.
                if (byte_end) begin
                    if (next_vld_q) begin
                        shift_d    = next_q;
                        next_vld_d = 1'b0;
                    end else if (dv_acc) begin
                        shift_d    = i_Fifo_Rd_Data;
                        next_vld_d = 1'b0;
                    end else if (!i_Enable) begin
                        state_d = ST_IDLE;
                    end else begin
                        underrun_d = 1'b1;
`ifdef MFM_WRITER_UNDERRUN_FILL_EN
                        shift_d = GAP_BYTE;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_out_d = rd_en ? 1'b1 : (dv_acc ? 1'b0 : rd_out_q);
    end

    // State and datapath registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'd0;
            cell_q     <= 4'd0;
            clk_cnt_q  <= 8'd0;
            prev_q     <= 1'b0;
            next_q     <= 8'd0;
            next_vld_q <= 1'b0;
            rd_out_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cell_q     <= cell_d;
            clk_cnt_q  <= clk_cnt_d;
            prev_q     <= prev_d;
            next_q     <= next_d;
            next_vld_q <= next_vld_d;
            rd_out_q   <= rd_out_d;
            underrun_q <= underrun_d;
        end
    end

    // Outputs; the read strobe is gated so it is low while reset is held.
    always_comb begin
        o_Fifo_Rd_En  = rd_en & i_Rst_L;
        o_Write_Gate  = (state_q == ST_SHIFT);
        o_Write_Pulse = (state_q == ST_SHIFT) && cell_val && (clk_cnt_q < PULSE_LEN);
        o_Busy        = (state_q != ST_IDLE);
        o_Underrun    = underrun_q;
    end

    // GAP_BYTE is only referenced when the fill option is built in.
    logic unused_gap;
    assign unused_gap = ^GAP_BYTE;

endmodule
